// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter for the ALU and load/memory writeback sources.
// Round-robin grant, registered write port, and a per-register busy scoreboard for decode hazards.
module regfile_wb_arbiter #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  input  logic [AW-1:0]   issue_rd,
  output logic            stall,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic [NREG-1:0] busy_vec
);

  // Handshake: a source holds valid/rd/data stable until it sees ready; a transfer
  // happens in any cycle where valid && ready, and ready never depends on rf_* state.
  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  src_e            r_last;
  logic            r_we;
  logic [AW-1:0]   r_rd;
  logic [XLEN-1:0] r_wdata;
  logic [NREG-1:0] r_busy;

  logic            w_issue_accept;
  logic [AW-1:0]   w_win_rd;
  logic [XLEN-1:0] w_win_data;
  logic            w_xfer;
  logic [NREG-1:0] w_busy_next;

  function automatic logic is_busy(input logic [NREG-1:0] v, input logic [AW-1:0] idx);
    return v[idx] && (idx != '0);
  endfunction

  // Ties go to the source that did not win the previous transfer.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!rst) begin
      if (alu_valid && (!mem_valid || r_last == SRC_MEM)) alu_ready = 1'b1;
      else if (mem_valid)                                 mem_ready = 1'b1;
    end
  end

  always_comb begin
    w_xfer     = (alu_valid && alu_ready) || (mem_valid && mem_ready);
    w_win_rd   = alu_ready ? alu_rd   : mem_rd;
    w_win_data = alu_ready ? alu_data : mem_data;
  end

  always_comb begin
    stall = !rst && issue_valid &&
            (is_busy(r_busy, issue_rs1) || is_busy(r_busy, issue_rs2) ||
             is_busy(r_busy, issue_rd));
    w_issue_accept = issue_valid && !stall;
  end

  // Release first, then reserve, so a same-edge reservation of the committing register survives.
  always_comb begin
    w_busy_next = r_busy;
    if (r_we && r_rd != '0) w_busy_next[r_rd] = 1'b0;
    if (w_issue_accept && issue_rd != '0) w_busy_next[issue_rd] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last  <= SRC_MEM;
      r_we    <= 1'b0;
      r_rd    <= '0;
      r_wdata <= '0;
      r_busy  <= '0;
    end else begin
      r_busy <= w_busy_next;
      r_we   <= 1'b0;
      if (w_xfer) begin
        r_last <= alu_ready ? SRC_ALU : SRC_MEM;
        // x0 writebacks complete the handshake but never reach the register file.
        if (w_win_rd != '0) begin
          r_we    <= 1'b1;
          r_rd    <= w_win_rd;
          r_wdata <= w_win_data;
        end
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_rd    = r_rd;
  assign rf_wdata = r_wdata;
  assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus constrained-random bench for regfile_wb_arbiter with a behavioural
// arbiter/scoreboard model and an expected-write queue.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int W    = AW + XLEN;

  logic            clk;
  logic            rst;
  logic            alu_valid, mem_valid, issue_valid;
  logic [AW-1:0]   alu_rd, mem_rd, issue_rs1, issue_rs2, issue_rd;
  logic [XLEN-1:0] alu_data, mem_data;
  logic            alu_ready, mem_ready, stall, rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [NREG-1:0] busy_vec;

  regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .stall(stall),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // model state
  logic [W-1:0]    exp_q[$];
  logic [NREG-1:0] m_busy     = '0;
  logic            m_last_mem = 1'b1;
  logic            m_we       = 1'b0;
  logic [AW-1:0]   m_rd       = '0;
  logic            g_alu      = 1'b0;
  logic            g_mem      = 1'b0;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic bz(input logic [AW-1:0] x);
    return m_busy[x] && (x != '0);
  endfunction

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
  endtask

  // One clock: combinational outputs checked at negedge, registered outputs #1 after posedge.
  task automatic cycle();
    logic            e_ar, e_mr, e_st;
    logic [NREG-1:0] nb;
    logic [W-1:0]    e;
    @(negedge clk);
    if (rst) begin
      e_ar = 1'b0; e_mr = 1'b0; e_st = 1'b0;
    end else begin
      e_ar = alu_valid && (!mem_valid || m_last_mem);
      e_mr = mem_valid && (!alu_valid || !m_last_mem);
      e_st = issue_valid && (bz(issue_rs1) || bz(issue_rs2) || bz(issue_rd));
    end
    chk("alu_ready", alu_ready, e_ar);
    chk("mem_ready", mem_ready, e_mr);
    chk("stall", stall, e_st);
    g_alu = e_ar;
    g_mem = e_mr;
    if (rst) begin
      exp_q.delete();
      m_busy = '0; m_last_mem = 1'b1;
    end else begin
      nb = m_busy;
      if (m_we && m_rd != '0) nb[m_rd] = 1'b0;
      if (issue_valid && !e_st && issue_rd != '0) nb[issue_rd] = 1'b1;
      m_busy = nb;
      if (e_ar) begin
        m_last_mem = 1'b0;
        if (alu_rd != '0) exp_q.push_back({alu_rd, alu_data});
      end else if (e_mr) begin
        m_last_mem = 1'b1;
        if (mem_rd != '0) exp_q.push_back({mem_rd, mem_data});
      end
    end
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rf_we", rf_we, 1'b1);
      chk("rf_rd", rf_rd, e[W-1:XLEN]);
      chk("rf_wdata", rf_wdata, e[XLEN-1:0]);
      m_we = 1'b1; m_rd = e[W-1:XLEN];
    end else begin
      chk("rf_we_idle", rf_we, 1'b0);
      m_we = 1'b0;
    end
    chk("busy_vec", busy_vec, m_busy);
  endtask

  initial begin
    idle();
    // T1: reset with both sources requesting
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'h44;
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 64'h66;
    issue_valid = 1'b1; issue_rd = 5'd9;
    cycle(); cycle();
    chk("rst_rf_rd", rf_rd, '0);
    chk("rst_rf_wdata", rf_wdata, '0);
    rst = 1'b0;
    idle();

    // T3: contention straight after reset, ALU wins first tie
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h1111;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'h2222;
    cycle(); chk("t3_rd0", rf_rd, 5'd1);
    cycle(); chk("t3_rd1", rf_rd, 5'd2);
    cycle(); chk("t3_rd2", rf_rd, 5'd1);
    cycle(); chk("t3_rd3", rf_rd, 5'd2);
    idle(); cycle();

    // T2: single ALU source
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hAB;
    cycle();
    chk("t2_we", rf_we, 1'b1);
    chk("t2_data", rf_wdata, 64'hAB);
    idle(); cycle();
    chk("t2_we_off", rf_we, 1'b0);

    // T4: x0 writeback from memory unit
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 64'hFF;
    cycle();
    chk("t4_we", rf_we, 1'b0);
    chk("t4_hold_data", rf_wdata, 64'hAB);
    idle(); cycle();

    // T5: RAW on x7
    issue_valid = 1'b1; issue_rd = 5'd7;
    cycle();
    chk("t5_busy7", busy_vec[7], 1'b1);
    issue_rs1 = 5'd7; issue_rd = 5'd8;
    cycle();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
    cycle();
    alu_valid = 1'b0;
    cycle();
    chk("t5_busy7_clr", busy_vec[7], 1'b0);
    cycle();
    chk("t5_busy8", busy_vec[8], 1'b1);
    idle();
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 64'h88;
    cycle(); idle(); cycle();

    // T6: WAW stall, then same-edge release/reserve of x3
    issue_valid = 1'b1; issue_rd = 5'd3;
    cycle();
    cycle();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
    cycle(); idle(); cycle();
    chk("t6_busy3_clr", busy_vec[3], 1'b0);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h3333;
    cycle();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd3;
    cycle();
    chk("t6_set_wins", busy_vec[3], 1'b1);
    idle();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h3;
    cycle(); idle(); cycle();

    // reset mid-operation: in-flight write dropped, pointer restored
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 64'h99;
    issue_valid = 1'b1; issue_rd = 5'd10;
    cycle();
    idle();
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 64'hBB;
    cycle();
    chk("mid_rst_busy", busy_vec, '0);
    rst = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 64'hCC;
    cycle();
    chk("mid_rst_alu_first", rf_rd, 5'd11);
    idle(); cycle(); cycle();

    // random traffic honouring the hold-until-ready rule
    for (int i = 0; i < 80; i++) begin
      if (!alu_valid || g_alu) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_rd    = AW'($urandom_range(0, 15));
        alu_data  = {32'($urandom), 32'($urandom)};
      end
      if (!mem_valid || g_mem) begin
        mem_valid = 1'($urandom_range(0, 1));
        mem_rd    = AW'($urandom_range(0, 15));
        mem_data  = {32'($urandom), 32'($urandom)};
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rs1   = AW'($urandom_range(0, 15));
      issue_rs2   = AW'($urandom_range(0, 15));
      issue_rd    = AW'($urandom_range(0, 15));
      cycle();
    end
    idle(); cycle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
